// File: rtl/l1_cache.sv
// Direct-mapped write-back, write-allocate L1 cache between the CPU cmem
// port and a 256-bit line port to L2; hits answer in the presenting cycle.
module l1_cache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         hit,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 27 - IW;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  state_e state_q, state_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic missed_q, missed_d;
  logic [TW-1:0] tag_q [NUM_SETS];
  logic [255:0] data_q [NUM_SETS];

  logic [IW-1:0] idx;
  logic [TW-1:0] atag;
  logic [7:0] wofs;
  logic req, tag_hit;
  logic [255:0] cur_line, wr_line, line_d;
  logic [31:0] cur_word, merged;
  logic line_we, tag_we;
  logic unused_addr;

  assign idx = mem_address[5+IW-1:5];
  assign atag = mem_address[31:5+IW];
  assign wofs = {mem_address[4:2], 5'b0};
  assign unused_addr = ^mem_address[1:0];
  assign req = mem_read | mem_write;
  assign tag_hit = valid_q[idx] && (tag_q[idx] == atag);
  assign cur_line = data_q[idx];
  assign cur_word = cur_line[wofs +: 32];

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = mem_byte_enable[b] ? mem_wdata[8*b +: 8]
                                            : cur_word[8*b +: 8];
    end
    wr_line = cur_line;
    wr_line[wofs +: 32] = merged;
  end

  assign pmem_read = (state_q == ALLOCATE);
  assign pmem_write = (state_q == WRITEBACK);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    missed_d = missed_q;
    line_we = 1'b0;
    line_d = pmem_rdata;
    tag_we = 1'b0;
    mem_resp = 1'b0;
    hit = 1'b0;
    mem_rdata = '0;
    pmem_address = '0;
    pmem_wdata = '0;
    unique case (state_q)
      COMPARE: begin
        if (req && tag_hit) begin
          mem_resp = 1'b1;
          hit = !missed_q;
          mem_rdata = cur_word;
          missed_d = 1'b0;
          if (mem_write) begin
            line_we = 1'b1;
            line_d = wr_line;
            dirty_d[idx] = 1'b1;
          end
        end else if (req) begin
          missed_d = 1'b1;
          state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK
                                                   : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_address = {tag_q[idx], idx, 5'b0};
        pmem_wdata = cur_line;
        if (pmem_resp) begin
          dirty_d[idx] = 1'b0;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_address = {atag, idx, 5'b0};
        if (pmem_resp) begin
          line_we = 1'b1;
          tag_we = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d = COMPARE;
        end
      end
      default: state_d = COMPARE;
    endcase
  end

  // Reset wins over a coincident pmem_resp, aborting any line transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COMPARE;
      valid_q <= '0;
      dirty_q <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      missed_q <= missed_d;
      if (line_we) data_q[idx] <= line_d;
      if (tag_we) tag_q[idx] <= atag;
    end
  end

endmodule
